mult_arbiter: RTL
=================

# mult_arbiter

Round-robin arbiter and sequencer that shares one `booth_mult_unsigned` instance between `NUM_REQ` requesters. It captures the winning requester's operands and pulses the multiplier enable. It then holds the operands stable until the multiplier signals done, and returns the product to the winner with a one-cycle done strobe. It sits between the requesting datapath blocks and the single multiplier instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, operand width; must match the multiplier's `DATA_WIDTH`
- `TIMEOUT_CYCLES`, 64, WAIT-state watchdog limit (used only with `MULT_ARB_TIMEOUT_EN`)
- `clk_i_arb`  in  1  clock; all logic rising-edge
- `rst_i_arb`  in  1  asynchronous, active-high reset
- `req_i`  in  NUM_REQ  per-requester request level
- `a_i`  in  NUM_REQ*DATA_WIDTH  flattened multipliers; slice k is `a_i[k*DATA_WIDTH +: DATA_WIDTH]`
- `b_i`  in  NUM_REQ*DATA_WIDTH  flattened multiplicands, same slicing
- `gnt_o`  out  NUM_REQ  one-hot grant, held from ISSUE through RESP
- `done_o`  out  NUM_REQ  one-hot, one-cycle completion strobe
- `result_o`  out  2*DATA_WIDTH  product; valid while any `done_o` bit is high, otherwise held
- `err_o`  out  1  timeout flag, valid with `done_o`
- `busy_o`  out  1  high in every state except IDLE
- `mult_en_o`  out  1  multiplier enable, one-cycle pulse
- `mult_a_o`, `mult_b_o`  out  DATA_WIDTH  operands to the multiplier, registered
- `mult_result_i`  in  2*DATA_WIDTH  multiplier product
- `mult_done_i`  in  1  multiplier done pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if `req_i != 0`:
  - pick the winner by round-robin, searching from index `ptr+1` upward with wrap.
  - latch the winner index.
  - register its `a_i`/`b_i` slices into `mult_a_o`/`mult_b_o`.
  - go to ISSUE.
- ISSUE: `mult_en_o=1` for exactly this cycle; go to WAIT.
- WAIT: on `mult_done_i=1`, capture `mult_result_i` into `result_o` and go to RESP.
- RESP: `done_o[winner]=1`; set `ptr<=winner`; go to IDLE.
- `mult_a_o`/`mult_b_o` hold constant from ISSUE through RESP. The multiplier samples B while idle and A one cycle later, so this stability is mandatory.
- `mult_done_i` is ignored in IDLE, ISSUE and RESP.
- Dropping `req_i[k]` after grant does not abort the transaction; done is still pulsed.
- A requester holds `req_i` and its operands until it sees its `done_o`.
  - If `req_i` is still high in the cycle after `done_o`, it is treated as a new request.
  - Round-robin places that requester last in priority.
- Reset values:
  - state IDLE; `ptr=NUM_REQ-1`, so requester 0 has first priority.
  - `gnt_o`, `done_o`, `result_o`, `err_o`, `busy_o`, `mult_en_o`, `mult_a_o`, `mult_b_o` all 0.
- Reset mid-operation: returns immediately to the reset state; no `done_o` is issued for the aborted transaction.
  - The integrator drives the multiplier's active-low reset from `~rst_i_arb`, so both reset together.

## Timing
- Grant latency: `req_i` sampled high in IDLE at edge N gives `gnt_o` and `busy_o` high after N. `mult_en_o` is high in the following cycle (ISSUE).
- Completion: `done_o` and `result_o` are valid the cycle after `mult_done_i` is sampled.
- Arbiter overhead per transaction: 3 cycles (IDLE, ISSUE, RESP) plus the multiplier latency.
- Back-to-back: a new grant is possible in the cycle after RESP, i.e. at most one transaction in flight.
- Simultaneous requests are resolved strictly by `ptr`; a waiting requester is served within `NUM_REQ-1` transactions.

## Configuration
- Macro: `MULT_ARB_TIMEOUT_EN`.
- Defined:
  - a counter runs in WAIT.
  - if `TIMEOUT_CYCLES` cycles elapse without `mult_done_i`, the FSM goes to RESP with `err_o=1` and `result_o=0`.
  - `mult_done_i` arriving in the same cycle as the timeout wins: `err_o=0`.
  - the counter clears on entry to WAIT.
- Undefined: no counter; `err_o` tied to 0; WAIT lasts until `mult_done_i`.

## Test plan
- Single request: `req_i=0001`, a=12, b=13 -> `mult_en_o` one-cycle pulse; `done_o=0001` with `result_o=156`, `err_o=0`.
- Simultaneous: `req_i=1111` from reset, a_k=k+2, b_k=10 -> grants in order 0,1,2,3 with results 20,30,40,50.
- Fairness: requester 1 holds req continuously while requester 2 requests once -> sequence 1,2,1.
- Operand stability: change `a_i` and `b_i` of the granted requester during WAIT -> `mult_a_o`/`mult_b_o` unchanged; result matches the original operands (255*255=65025).
- Reset mid-WAIT: assert `rst_i_arb` -> all outputs 0 next cycle; no `done_o`; the next request is served normally.
- Timeout (macro defined, `TIMEOUT_CYCLES=16`): `mult_done_i` held 0 -> `done_o` with `err_o=1` and `result_o=0` after 16 WAIT cycles; `busy_o` drops the following cycle.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one multiplier between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk_i_arb,
  input  logic                            rst_i_arb,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   b_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic [2*DATA_WIDTH-1:0]         result_o,
  output logic                            err_o,
  output logic                            busy_o,
  output logic                            mult_en_o,
  output logic [DATA_WIDTH-1:0]           mult_a_o,
  output logic [DATA_WIDTH-1:0]           mult_b_o,
  input  logic [2*DATA_WIDTH-1:0]         mult_result_i,
  input  logic                            mult_done_i
);

  // state | meaning
  // IDLE  | no transaction; arbitrate among req_i
  // ISSUE | operands registered, mult_en_o pulsed
  // WAIT  | operands held until mult_done_i (or watchdog expiry)
  // RESP  | done_o strobe to winner, pointer advanced
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                r_state;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_win;
  logic [IDX_W-1:0]      w_win;
  logic                  w_any;
  logic [NUM_REQ-1:0]    w_win_oh;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [DATA_WIDTH-1:0] w_a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_a_arr[g] = a_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_arr[g] = b_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_any    = |req_i;
  assign w_gnt_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;

  // Scan from farthest to nearest offset so the nearest requester after ptr wins.
  always_comb begin
    int               v_k;
    logic [IDX_W-1:0] v_idx;
    v_k   = 0;
    v_idx = '0;
    w_win = r_ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      v_k = int'(r_ptr) + i;
      if (v_k >= NUM_REQ) v_k = v_k - NUM_REQ;
      v_idx = IDX_W'(v_k);
      if (req_i[v_idx]) w_win = v_idx;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err;
  assign err_o = r_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk_i_arb or posedge rst_i_arb) begin
    if (rst_i_arb) begin
      r_state   <= S_IDLE;
      r_ptr     <= IDX_W'(NUM_REQ-1);
      r_win     <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      result_o  <= '0;
      busy_o    <= 1'b0;
      mult_en_o <= 1'b0;
      mult_a_o  <= '0;
      mult_b_o  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win     <= w_win;
            mult_a_o  <= w_a_arr[w_win];
            mult_b_o  <= w_b_arr[w_win];
            gnt_o     <= w_gnt_oh;
            busy_o    <= 1'b1;
            mult_en_o <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mult_en_o <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
          r_to_cnt  <= CNT_W'(TIMEOUT_CYCLES-1);
`endif
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the expiry cycle takes precedence over the watchdog.
          if (mult_done_i) begin
            result_o <= mult_result_i;
            done_o   <= w_win_oh;
            r_state  <= S_RESP;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (r_to_cnt == '0) begin
            result_o <= '0;
            r_err    <= 1'b1;
            done_o   <= w_win_oh;
            r_state  <= S_RESP;
          end else begin
            r_to_cnt <= r_to_cnt - CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          done_o  <= '0;
          gnt_o   <= '0;
          busy_o  <= 1'b0;
          r_ptr   <= r_win;
`ifdef MULT_ARB_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
